// File: rtl/capture_pkg.sv
// Shared defaults, state encoding and constants for the sample capture writer.
package capture_pkg;

    localparam int unsigned DefAddrW     = 15;
    localparam int unsigned DefDataW     = 32;
    localparam int unsigned DefFifoDepth = 4;

    localparam logic [3:0] ByteEnAll = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRun,
        StFlush
    } capture_state_e;

endpackage

// File: rtl/capture_skid_fifo.sv
// Small skid FIFO between the sample stream and the memory port.
// Depth must be a power of two, at least 2; the caller never pushes into a full FIFO
// unless it pops in the same cycle.
module capture_skid_fifo
    import capture_pkg::*;
#(
    parameter int unsigned Width = DefDataW,
    parameter int unsigned Depth = DefFifoDepth
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wr_ptr_q, rd_ptr_q;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sample_capture_writer.sv
// Captures a triggered sample stream into RAM, either as a fixed-length block or as a ring,
// with a skid FIFO absorbing cycles where the memory port is not granted.
module sample_capture_writer
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              cfg_wrap,
    input  logic              trig,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    input  logic              mem_grant,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   wr_count
);

    capture_state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, addr_q, addr_d, last_addr, mem_address_q, mem_address_d;
    logic [ADDR_W:0]   len_q, push_cnt_q, push_cnt_d, wr_count_q, wr_count_d, wr_limit;
    logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d, fifo_rdata;
    logic [3:0]        mem_byteenable_q, mem_byteenable_d;
    logic              wrap_q, mem_write_q, done_q, done_d, overflow_q, overflow_d;
    logic              start, abort, want_push, push, pop, drop, fifo_flush;
    logic              fifo_full, fifo_empty;

    capture_skid_fifo #(
        .Width (DATA_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (push),
        .push_data (snk_data),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ring wraps after the last word; a full-size ring (len = 2^ADDR_W) wraps at base-1.
    assign last_addr = base_q + len_q[ADDR_W-1:0] - ADDR_W'(1);
    assign wr_limit  = wrap_q ? {1'b1, {ADDR_W{1'b0}}} : len_q;

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        push_cnt_d       = push_cnt_q;
        wr_count_d       = wr_count_q;
        done_d           = done_q;
        overflow_d       = overflow_q;
        mem_address_d    = mem_address_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = '0;

        abort      = cfg_abort || (state_q == StArmed && cfg_stop);
        start      = (state_q == StIdle) && cfg_start && !cfg_abort;
        fifo_flush = start || abort;
        pop        = !fifo_empty && mem_grant && !abort &&
                     (state_q == StRun || state_q == StFlush);
        want_push  = (state_q == StRun) && snk_valid && !abort &&
                     (wrap_q || push_cnt_q < len_q);
        push       = want_push && (!fifo_full || pop);
        drop       = want_push && fifo_full && !pop;

        if (push && !wrap_q) push_cnt_d = push_cnt_q + (ADDR_W + 1)'(1);
        if (drop)            overflow_d = 1'b1;

        if (pop) begin
            mem_address_d    = addr_q;
            mem_writedata_d  = fifo_rdata;
            mem_byteenable_d = ByteEnAll;
            addr_d           = (wrap_q && addr_q == last_addr) ? base_q : addr_q + ADDR_W'(1);
            if (wr_count_q != wr_limit) wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
        end

        unique case (state_q)
            StIdle:  if (start) state_d = StArmed;
            StArmed: if (trig) state_d = StRun;
            StRun: begin
                if (cfg_stop || (!wrap_q && push_cnt_d == len_q)) state_d = StFlush;
            end
            StFlush: begin
                if (fifo_empty && !mem_write_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            addr_d     = cfg_base;
            push_cnt_d = '0;
            wr_count_d = '0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
        end

        if (abort) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            base_q           <= '0;
            len_q            <= '0;
            wrap_q           <= 1'b0;
            addr_q           <= '0;
            push_cnt_q       <= '0;
            wr_count_q       <= '0;
            done_q           <= 1'b0;
            overflow_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
        end else begin
            state_q          <= state_d;
            if (start) begin
                base_q <= cfg_base;
                len_q  <= cfg_len;
                wrap_q <= cfg_wrap;
            end
            addr_q           <= addr_d;
            push_cnt_q       <= push_cnt_d;
            wr_count_q       <= wr_count_d;
            done_q           <= done_d;
            overflow_q       <= overflow_d;
            mem_write_q      <= pop;
            mem_address_q    <= mem_address_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_byteenable_q <= mem_byteenable_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_chipselect = mem_write_q;
    assign mem_write      = mem_write_q;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign overflow       = overflow_q;
    assign wr_count       = wr_count_q;

endmodule
